// File: rtl/match_score_tracker.sv
// Match scorekeeper: accepts per-round results, counts rounds and per-player wins,
// and reports a registered running winner and a match-finished flag.
module match_score_tracker #(
    parameter int MAX_ROUNDS = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             result_valid,
    input  logic [1:0]       result,
    output logic             result_ready,
    output logic [CNT_W-1:0] round,
    output logic [CNT_W-1:0] win,
    output logic [CNT_W-1:0] lose,
    output logic             fin,
    output logic [1:0]       winner,
    output logic             err,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ROUNDS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] round_q, round_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] lose_q, lose_d;
    logic [1:0]       winner_q, winner_d;
    logic             err_q, err_d;
    logic             xfer;

    // Handshake: a result transfers on a rising edge where result_valid and
    // result_ready are both high; result_ready depends on state only, never on valid.
    assign result_ready = (state_q == PLAY);
    assign xfer         = result_valid & result_ready;

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        win_d   = win_q;
        lose_d  = lose_q;
        err_d   = 1'b0;

        // start restarts from any state and overrides a same-cycle transfer
        if (start) begin
            state_d = PLAY;
            round_d = '0;
            win_d   = '0;
            lose_d  = '0;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                PLAY: begin
                    if (xfer) begin
                        case (result)
                            2'b10: begin
                                round_d = round_q + 1'b1;
                                win_d   = win_q + 1'b1;
                            end
                            2'b11: begin
                                round_d = round_q + 1'b1;
                                lose_d  = lose_q + 1'b1;
                            end
                            2'b01: round_d = round_q + 1'b1;
                            default: err_d = 1'b1;
                        endcase
                        if (round_d == MAX_CNT) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end

        // Derived from next-state counts so winner never lags win/lose
        if (win_d > lose_d) begin
            winner_d = 2'b10;
        end else if (lose_d > win_d) begin
            winner_d = 2'b11;
        end else begin
            winner_d = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            round_q  <= '0;
            win_q    <= '0;
            lose_q   <= '0;
            winner_q <= 2'b01;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            win_q    <= win_d;
            lose_q   <= lose_d;
            winner_q <= winner_d;
            err_q    <= err_d;
        end
    end

    assign round     = round_q;
    assign win       = win_q;
    assign lose      = lose_q;
    assign fin       = (state_q == DONE);
    assign winner    = winner_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: doc/match_score_tracker.md
Name: match_score_tracker

Overview:
- Sequential scorekeeper that produces the round, win and lose counts consumed by the game-end checker.
- Accepts one per-round result at a time from the round-judge logic over a valid/ready handshake, counts rounds and per-player wins, and declares the match finished after MAX_ROUNDS rounds.
- Provides a registered running winner code for the display path.

Parameters:
- MAX_ROUNDS, 8, number of counted rounds per match; legal range 1..15; fin asserts when round equals this value.
- CNT_W, 4, width of the round, win and lose counters; must hold MAX_ROUNDS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
- start  input  1  single-cycle request to begin a new match; clears all counters.
- result_valid  input  1  round result present on result.
- result  input  2  round outcome: 2'b10 = P1 wins, 2'b11 = P2 wins, 2'b01 = draw, 2'b00 = illegal.
- result_ready  output  1  tracker can accept a result this cycle.
- round  output  CNT_W  rounds completed in the current match.
- win  output  CNT_W  rounds won by P1.
- lose  output  CNT_W  rounds won by P2.
- fin  output  1  match finished; high in DONE.
- winner  output  2  2'b10 = win>lose, 2'b11 = lose>win, 2'b01 = equal; registered.
- err  output  1  one-cycle pulse on acceptance of an illegal result code.

Behaviour:
- States: IDLE, PLAY, DONE. Reset enters IDLE immediately (asynchronous).
- Reset values: round=0, win=0, lose=0, fin=0, winner=2'b01, err=0, result_ready=0.
- result_ready = 1 only in PLAY; it is a function of state only and does not depend on result_valid.
- Transfer occurs on a rising edge with result_valid & result_ready.
- IDLE:
  - start -> PLAY; counters cleared to 0; winner=2'b01.
  - result_valid is ignored.
- PLAY, on transfer:
  - 10: round+1, win+1.
  - 11: round+1, lose+1.
  - 01: round+1 only.
  - 00: no counter change; err pulses high for exactly the following cycle.
- PLAY -> DONE on the same edge at which round becomes MAX_ROUNDS.
  - fin=1 from that cycle onward.
  - result_ready=0 from that cycle onward.
- DONE:
  - Counters and winner hold.
  - start -> PLAY with counters cleared and fin=0 on that edge.
- start while in PLAY restarts the match: counters cleared, state stays PLAY. Any result transferred that same cycle is discarded (start has priority; no err pulse).
- winner is updated on the same edge as the counters, from the next-state win/lose values, so it is always consistent with the win/lose outputs.
- Counters never wrap. round is bounded by MAX_ROUNDS, and win+lose <= round.
- Invariants: round = win + lose + draws; fin = (state==DONE).
- Reset asserted mid-match returns to IDLE with all reset values within the same cycle. The first match after reset requires start.
- Latency: one clock from transfer to updated counters and winner.

Test Plan:
- Reset, then start, then 8 results of 10 -> after the 8th transfer, win=8, lose=0, round=8, fin=1, winner=10, and result_ready=0 on the next cycle.
- Sequence 10,11,01,11,11,01,10,11 -> final win=2, lose=4, round=8, winner=11, fin=1; an extra result_valid in DONE produces no change.
- Sequence 10,11,01,01,10,11,01,01 -> win=2, lose=2, winner=01 after each equal point; fin=1 after the 8th transfer.
- Result 00 in PLAY at round=3 -> round stays 3, err high for exactly 1 cycle, and the next legal result advances round to 4.
- start asserted with result_valid=1 and result=10 at round=5 -> round=0, win=0, lose=0, state PLAY, err=0.
- reset_n driven low asynchronously mid-cycle at round=6 -> all outputs take reset values before the next edge, and results are ignored until start.
